pwm_capture_axi_stream: RTL and testbench

Receive-side counterpart to the team's AXI-Stream-to-PWM generator: samples a single-wire PWM line using 32-cycle frames, measures the high time of each frame and emits it as a 5-bit AXI-Stream beat. Sits at the far end of a PWM link, or in loop-back against the generator, so that duty values 1..31 round-trip unchanged.

---
 rtl/pwm_link_pkg.sv | 22 ++
 rtl/pwm_sync.sv | 30 +++
 rtl/pwm_capture_axi_stream.sv | 175 +++++++++++++++++
 tb/tb_pwm_capture_axi_stream.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_link_pkg.sv
// Shared definitions for the PWM link: frame geometry, the capture FSM state set
// and small helpers used on both the generator and the capture side.
package pwm_link_pkg;

    localparam int FRAME_LEN = 32;
    localparam int DATA_W    = 5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        HIGH  = 2'd1,
        GUARD = 2'd2,
        STUCK = 2'd3
    } pwm_state_e;

    localparam logic [DATA_W-1:0] WIN_LAST = 5'd31;

    // True on the final cycle of a frame window.
    function automatic logic is_last_cycle(input logic [DATA_W-1:0] win);
        return (win == WIN_LAST);
    endfunction

endpackage

// File: rtl/pwm_sync.sv
// Input synchronizer for the asynchronous PWM line: a SYNC_STAGES flop chain
// plus one extra flop giving the previous synchronized sample for edge detection.
module pwm_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic in_clock,
    input  logic in_reset_n,
    input  logic in_pwm,
    output logic s,
    output logic s_prev
);

    logic [SYNC_STAGES-1:0] sync_r;
    logic                   prev_r;

    // Shift the raw line through the chain and keep one sample of history.
    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            sync_r <= {SYNC_STAGES{1'b0}};
            prev_r <= 1'b0;
        end else begin
            sync_r <= {sync_r[SYNC_STAGES-2:0], in_pwm};
            prev_r <= sync_r[SYNC_STAGES-1];
        end
    end

    assign s      = sync_r[SYNC_STAGES-1];
    assign s_prev = prev_r;

endmodule

// File: rtl/pwm_capture_axi_stream.sv
// PWM capture: measures the high time of each 32-cycle frame on a synchronized
// PWM line and presents it on a single-entry AXI-Stream output register.
module pwm_capture_axi_stream
    import pwm_link_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic              in_clock,
    input  logic              in_reset_n,
    input  logic              in_pwm,
    input  logic              in_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_overrun,
    output logic              out_frame_err
);

    logic [1:0]             rst_sync_r;
    logic                   rst_n_s;
    logic [SYNC_STAGES-1:0] fill_r;
    logic                   s_s;
    logic                   s_prev_s;
    logic                   armed_r;
    logic                   rise_s;

    pwm_state_e             state_r;
    pwm_state_e             state_nx_s;
    logic [DATA_W-1:0]      win_r;
    logic [DATA_W-1:0]      win_nx_s;
    logic [DATA_W-1:0]      width_r;
    logic [DATA_W-1:0]      width_nx_s;
    logic                   publish_s;
    logic                   err_set_s;

    logic                   valid_r;
    logic [DATA_W-1:0]      data_r;
    logic                   overrun_r;
    logic                   frame_err_r;
    logic                   accept_s;
    logic                   load_s;
    logic                   drop_s;

    // Reset is taken asynchronously and released on a clock edge.
    always_ff @(posedge in_clock or negedge in_reset_n) begin
        if (!in_reset_n) begin
            rst_sync_r <= 2'b00;
        end else begin
            rst_sync_r <= {rst_sync_r[0], 1'b1};
        end
    end

    assign rst_n_s = rst_sync_r[1];

    pwm_sync #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .in_clock   (in_clock),
        .in_reset_n (rst_n_s),
        .in_pwm     (in_pwm),
        .s          (s_s),
        .s_prev     (s_prev_s)
    );

    // A line already high when reset releases must not look like a fresh edge:
    // edges count only after the chain has filled and a low sample was seen.
    always_ff @(posedge in_clock or negedge rst_n_s) begin
        if (!rst_n_s) begin
            fill_r  <= {SYNC_STAGES{1'b0}};
            armed_r <= 1'b0;
        end else begin
            fill_r  <= {fill_r[SYNC_STAGES-2:0], 1'b1};
            armed_r <= armed_r | (fill_r[SYNC_STAGES-1] & ~s_s);
        end
    end

    assign rise_s = s_s & ~s_prev_s & armed_r;

    // win_r holds the index of the current frame cycle; the edge cycle is index 0,
    // so the value loaded on an edge is already 1.
    always_comb begin
        state_nx_s = state_r;
        win_nx_s   = win_r + 5'd1;
        width_nx_s = width_r;
        publish_s  = 1'b0;
        err_set_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (rise_s) begin
                    win_nx_s   = 5'd1;
                    width_nx_s = 5'd1;
                    state_nx_s = HIGH;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            HIGH: begin
                if (s_s) begin
                    if (is_last_cycle(win_r)) begin
                        err_set_s  = 1'b1;
                        state_nx_s = STUCK;
                    end else begin
                        width_nx_s = width_r + 5'd1;
                    end
                end else begin
                    publish_s  = 1'b1;
                    state_nx_s = is_last_cycle(win_r) ? IDLE : GUARD;
                end
            end
            GUARD: begin
                if (rise_s && !is_last_cycle(win_r)) begin
                    err_set_s  = 1'b1;
                    win_nx_s   = 5'd1;
                    width_nx_s = 5'd1;
                    state_nx_s = HIGH;
                end else if (is_last_cycle(win_r)) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = GUARD;
                end
            end
            STUCK: begin
                if (!s_s) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = STUCK;
                end
            end
            default: begin
                state_nx_s = IDLE;
            end
        endcase
    end

    // Capture FSM and frame counters.
    always_ff @(posedge in_clock or negedge rst_n_s) begin
        if (!rst_n_s) begin
            state_r <= IDLE;
            win_r   <= 5'd0;
            width_r <= 5'd0;
        end else begin
            state_r <= state_nx_s;
            win_r   <= win_nx_s;
            width_r <= width_nx_s;
        end
    end

    assign accept_s = valid_r & in_ready;
    assign load_s   = publish_s & (~valid_r | accept_s);
    assign drop_s   = publish_s & valid_r & ~in_ready;

    // Single-entry output beat plus the sticky error flags.
    always_ff @(posedge in_clock or negedge rst_n_s) begin
        if (!rst_n_s) begin
            valid_r     <= 1'b0;
            data_r      <= 5'd0;
            overrun_r   <= 1'b0;
            frame_err_r <= 1'b0;
        end else begin
            if (load_s) begin
                valid_r <= 1'b1;
                data_r  <= width_r;
            end else if (accept_s) begin
                valid_r <= 1'b0;
            end
            overrun_r   <= overrun_r | drop_s;
            frame_err_r <= frame_err_r | err_set_s;
        end
    end

    assign out_valid     = valid_r;
    assign out_data      = data_r;
    assign out_overrun   = overrun_r;
    assign out_frame_err = frame_err_r;

endmodule

// File: tb/tb_pwm_capture_axi_stream.sv
// Self-checking bench for pwm_capture_axi_stream: directed scenarios plus a
// randomized loop-back run scored against the widths the bench itself sent.
module tb_pwm_capture_axi_stream;

    localparam int SYNC = 2;

    logic       in_clock = 1'b0;
    logic       in_reset_n = 1'b0;
    logic       in_pwm = 1'b0;
    logic       in_ready = 1'b0;
    logic       out_valid;
    logic [4:0] out_data;
    logic       out_overrun;
    logic       out_frame_err;

    int checks = 0;
    int errors = 0;
    int acc[$];

    pwm_capture_axi_stream #(.SYNC_STAGES(SYNC)) dut (
        .in_clock      (in_clock),
        .in_reset_n    (in_reset_n),
        .in_pwm        (in_pwm),
        .in_ready      (in_ready),
        .out_valid     (out_valid),
        .out_data      (out_data),
        .out_overrun   (out_overrun),
        .out_frame_err (out_frame_err)
    );

    always #5 in_clock = ~in_clock;

    // One cycle: drive inputs on the falling edge and record a handshake that
    // the next rising edge will complete.
    task automatic step(input logic pwm, input logic rdy);
        @(negedge in_clock);
        in_pwm   = pwm;
        in_ready = rdy;
        if (out_valid && in_ready) acc.push_back(int'(out_data));
    endtask

    task automatic send_frame(input int w, input logic rdy);
        for (int i = 0; i < 32; i++) step(i < w, rdy);
    endtask

    task automatic idle(input int n, input logic rdy);
        for (int i = 0; i < n; i++) step(1'b0, rdy);
    endtask

    task automatic do_reset();
        @(negedge in_clock);
        in_reset_n = 1'b0;
        idle(3, 1'b0);
        @(negedge in_clock);
        in_reset_n = 1'b1;
        idle(8, 1'b0);
        acc.delete();
    endtask

    task automatic test_reset();
        idle(3, 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 5'd0) begin errors++; $display("FAIL reset_data got %0d want 0", out_data); end
        checks++; if (out_overrun !== 1'b0) begin errors++; $display("FAIL reset_overrun got %b want 0", out_overrun); end
        checks++; if (out_frame_err !== 1'b0) begin errors++; $display("FAIL reset_frame_err got %b want 0", out_frame_err); end
        @(negedge in_clock);
        in_reset_n = 1'b1;
        idle(8, 1'b0);
    endtask

    task automatic test_loopback();
        int exp_q[$];
        exp_q = '{1, 5, 16, 31};
        foreach (exp_q[i]) send_frame(exp_q[i], 1'b1);
        idle(10, 1'b1);
        checks++;
        if (acc.size() != exp_q.size()) begin
            errors++; $display("FAIL loopback_count got %0d want %0d", acc.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (acc[i] != exp_q[i]) begin errors++; $display("FAIL loopback_beat%0d got %0d want %0d", i, acc[i], exp_q[i]); end
            end
        end
        checks++; if (out_overrun !== 1'b0) begin errors++; $display("FAIL loopback_overrun got %b want 0", out_overrun); end
        checks++; if (out_frame_err !== 1'b0) begin errors++; $display("FAIL loopback_frame_err got %b want 0", out_frame_err); end
    endtask

    task automatic test_latency();
        int lat;
        lat = 0;
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        for (int k = 1; k <= 10; k++) begin
            step(1'b0, 1'b0);
            if (out_valid === 1'b1) begin lat = k; break; end
        end
        checks++; if (lat != SYNC + 1) begin errors++; $display("FAIL latency got %0d want %0d", lat, SYNC + 1); end
        checks++; if (out_data !== 5'd5) begin errors++; $display("FAIL latency_data got %0d want 5", out_data); end
        idle(40, 1'b1);
    endtask

    task automatic test_overrun();
        send_frame(7, 1'b0);
        send_frame(9, 1'b0);
        idle(36, 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL overrun_valid got %b want 1", out_valid); end
        checks++; if (out_data !== 5'd7) begin errors++; $display("FAIL overrun_held got %0d want 7", out_data); end
        checks++; if (out_overrun !== 1'b1) begin errors++; $display("FAIL overrun_flag got %b want 1", out_overrun); end
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL overrun_after_accept got %b want 0", out_valid); end
        checks++;
        if (acc.size() != 1 || acc[0] != 7) begin
            errors++; $display("FAIL overrun_beats got size %0d first %0d want 1 beat of 7", acc.size(), (acc.size() > 0) ? acc[0] : -1);
        end
    endtask

    task automatic test_stuck();
        for (int i = 0; i < 40; i++) step(1'b1, 1'b1);
        checks++; if (out_frame_err !== 1'b1) begin errors++; $display("FAIL stuck_frame_err got %b want 1", out_frame_err); end
        checks++; if (acc.size() != 0) begin errors++; $display("FAIL stuck_no_beat got %0d beats want 0", acc.size()); end
        idle(10, 1'b1);
        send_frame(12, 1'b1);
        idle(6, 1'b1);
        checks++;
        if (acc.size() != 1 || acc[0] != 12) begin
            errors++; $display("FAIL stuck_recover got size %0d first %0d want 1 beat of 12", acc.size(), (acc.size() > 0) ? acc[0] : -1);
        end
    endtask

    task automatic test_restart();
        for (int i = 0; i < 4; i++) step(1'b1, 1'b1);
        idle(10, 1'b1);
        for (int i = 0; i < 6; i++) step(1'b1, 1'b1);
        idle(40, 1'b1);
        checks++; if (out_frame_err !== 1'b1) begin errors++; $display("FAIL restart_frame_err got %b want 1", out_frame_err); end
        checks++;
        if (acc.size() != 2 || acc[0] != 4 || acc[1] != 6) begin
            errors++; $display("FAIL restart_beats got size %0d want beats 4 then 6", acc.size());
        end
        checks++; if (out_overrun !== 1'b0) begin errors++; $display("FAIL restart_overrun got %b want 0", out_overrun); end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0);
        idle(40, 1'b0);
        checks++; if (out_valid !== 1'b1 || out_data !== 5'd3) begin errors++; $display("FAIL b2b_first got valid %b data %0d want 1/3", out_valid, out_data); end
        for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);
        step(1'b0, 1'b1);
        step(1'b0, 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %b want 1", out_valid); end
        checks++; if (out_data !== 5'd8) begin errors++; $display("FAIL b2b_data got %0d want 8", out_data); end
        checks++; if (out_overrun !== 1'b0) begin errors++; $display("FAIL b2b_overrun got %b want 0", out_overrun); end
        step(1'b0, 1'b1);
        checks++;
        if (acc.size() != 2 || acc[0] != 3 || acc[1] != 8) begin
            errors++; $display("FAIL b2b_beats got size %0d want beats 3 then 8", acc.size());
        end
    endtask

    task automatic test_reset_midframe();
        send_frame(6, 1'b0);
        idle(4, 1'b0);
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL midrst_held got %b want 1", out_valid); end
        for (int i = 0; i < 5; i++) step(1'b1, 1'b0);
        in_reset_n = 1'b0;
        #1;
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %b want 0", out_valid); end
        checks++; if (out_data !== 5'd0) begin errors++; $display("FAIL midrst_data got %0d want 0", out_data); end
        for (int i = 0; i < 3; i++) step(1'b1, 1'b1);
        in_reset_n = 1'b1;
        for (int i = 0; i < 12; i++) step(1'b1, 1'b1);
        idle(40, 1'b1);
        checks++; if (acc.size() != 0) begin errors++; $display("FAIL midrst_remnant got %0d beats want 0", acc.size()); end
        send_frame(10, 1'b1);
        idle(6, 1'b1);
        checks++;
        if (acc.size() != 1 || acc[0] != 10) begin
            errors++; $display("FAIL midrst_next got size %0d first %0d want 1 beat of 10", acc.size(), (acc.size() > 0) ? acc[0] : -1);
        end
    endtask

    task automatic test_random();
        int         exp_q[$];
        int         w;
        int         gap;
        int         lowrun;
        logic       rdy;
        logic       pv;
        logic       pr;
        logic [4:0] pd;
        lowrun = 0;
        for (int f = 0; f < 24; f++) begin
            w   = int'($urandom_range(1, 31));
            gap = int'($urandom_range(0, 6));
            exp_q.push_back(w);
            for (int i = 0; i < 32 + gap; i++) begin
                rdy = ($urandom_range(0, 2) == 0) ? 1'b1 : 1'b0;
                if (lowrun >= 12) rdy = 1'b1;
                lowrun = rdy ? 0 : lowrun + 1;
                pv = out_valid;
                pr = in_ready;
                pd = out_data;
                step(i < w, rdy);
                if (pv && !pr) begin
                    checks++;
                    if (out_valid !== 1'b1 || out_data !== pd) begin
                        errors++; $display("FAIL rand_hold got valid %b data %0d want 1/%0d", out_valid, out_data, pd);
                    end
                end
            end
        end
        idle(40, 1'b1);
        checks++;
        if (acc.size() != exp_q.size()) begin
            errors++; $display("FAIL rand_count got %0d want %0d", acc.size(), exp_q.size());
        end else begin
            foreach (exp_q[i]) begin
                checks++;
                if (acc[i] != exp_q[i]) begin errors++; $display("FAIL rand_beat%0d got %0d want %0d", i, acc[i], exp_q[i]); end
            end
        end
        checks++; if (out_overrun !== 1'b0) begin errors++; $display("FAIL rand_overrun got %b want 0", out_overrun); end
        checks++; if (out_frame_err !== 1'b0) begin errors++; $display("FAIL rand_frame_err got %b want 0", out_frame_err); end
    endtask

    initial begin
        test_reset();
        test_loopback();
        do_reset();
        test_latency();
        do_reset();
        test_overrun();
        do_reset();
        test_stuck();
        do_reset();
        test_restart();
        do_reset();
        test_back_to_back();
        do_reset();
        test_reset_midframe();
        do_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
